// File: rtl/filter_bank_ctrl.sv
// Controller for a bank of I/Q switched-cap filter channels: shared clock generation,
// quadrature LO, comparator feedback sampling, windowed hit counting and a count stream FIFO.
module filter_bank_ctrl #(
  parameter int NCH        = 4,
  parameter int DIV_W      = 8,
  parameter int CNT_W      = 10,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int DW        = CH_W + CNT_W
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [CNT_W-1:0] win_i,
  input  logic [NCH-1:0]   high_buf_i,
  input  logic [NCH-1:0]   phi1b_dig_i,
  output logic             cclk_o,
  output logic             div2_o,
  output logic [NCH-1:0]   lo_o,
  output logic [NCH-1:0]   fb1_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [DW-1:0]    m_data_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DUMP = 1'b1;

  // Clock generation and window timing
  logic [DIV_W-1:0] dcnt;
  logic             cclk;
  logic             div2;
  logic [1:0]       q;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] win_last;
  logic             cclk_rise;
  logic             win_end;

  // Per-channel sampling
  logic [NCH-1:0]   high_s1, high_s2;
  logic [NCH-1:0]   phi_s1, phi_s2, phi_s3;
  logic [NCH-1:0]   phi_edge;
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   fb1;
  logic [CNT_W-1:0] hits   [NCH];
  logic [CNT_W-1:0] shadow [NCH];

  // Dump FSM and output FIFO
  logic [0:0]       state;
  logic [CH_W-1:0]  idx;
  logic             overflow;
  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic [DW-1:0]    push_data;

  assign win_last  = (win_i == '0) ? '0 : win_i - 1'b1;
  assign cclk_rise = en_i && (dcnt == div_i) && !cclk;
  assign win_end   = cclk_rise && (wcnt == win_last);

  // NOTE: sequential state always uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !en_i) begin
      dcnt <= '0;
      cclk <= 1'b0;
      div2 <= 1'b0;
      q    <= '0;
      wcnt <= '0;
    end else begin
      if (dcnt == div_i) begin
        dcnt <= '0;
        cclk <= ~cclk;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      if (cclk_rise) begin
        div2 <= ~div2;
        q    <= q + 2'd1;
        wcnt <= win_end ? '0 : wcnt + 1'b1;
      end
    end
  end

  // NOTE: every variable written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    lo_o = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      // Odd (Q) channels lead the even (I) channels by one cclk period.
      lo_o[ch] = (ch % 2 == 1) ? (q[1] ^ q[0]) : q[1];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      high_s1 <= '0;
      high_s2 <= '0;
      phi_s1  <= '0;
      phi_s2  <= '0;
      phi_s3  <= '0;
      fb1     <= '0;
    end else begin
      high_s1 <= high_buf_i;
      high_s2 <= high_s1;
      phi_s1  <= phi1b_dig_i;
      phi_s2  <= phi_s1;
      phi_s3  <= phi_s2;
      for (int ch = 0; ch < NCH; ch++) begin
        if (phi_edge[ch]) fb1[ch] <= high_s2[ch];
      end
    end
  end

  assign phi_edge = phi_s2 & ~phi_s3;
  assign hit      = phi_edge & high_s2;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !en_i) begin
      for (int ch = 0; ch < NCH; ch++) hits[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (win_end) begin
          // A hit landing on the window boundary belongs to the new window.
          hits[ch] <= CNT_W'(hit[ch]);
        end else if (hit[ch] && hits[ch] != '1) begin
          hits[ch] <= hits[ch] + 1'b1;
        end
      end
    end
  end

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = (state == DUMP) && !full;
  assign pop       = m_valid_o && m_ready_i;
  assign push_data = {idx, shadow[idx]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      idx      <= '0;
      overflow <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) shadow[ch] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_end) begin
            for (int ch = 0; ch < NCH; ch++) shadow[ch] <= hits[ch];
            idx   <= '0;
            state <= DUMP;
          end
        end
        default: begin
          // The pending snapshot wins; a newer one is lost and flagged.
          if (win_end) overflow <= 1'b1;
          if (push) begin
            if (idx == CH_W'(NCH - 1)) state <= IDLE;
            else                       idx   <= idx + 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: the FIFO storage array is deliberately left without reset; only the
  // pointers and count are reset, and the head is meaningful only while valid.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign cclk_o     = cclk;
  assign div2_o     = div2;
  assign fb1_o      = fb1;
  assign m_valid_o  = !empty;
  assign m_data_o   = mem[rd_ptr];
  assign overflow_o = overflow;

endmodule
